// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode responder and the host command engine:
// command indices, R1 flag bits, frame length and the responder state encoding.
package sd_pkg;

  localparam int FRAME_LEN = 48;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD16  = 6'd16;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] CMD59  = 6'd59;

  localparam logic [7:0] R1_IDLE      = 8'h01;
  localparam logic [7:0] R1_ILLEGAL   = 8'h04;
  localparam logic [7:0] R1_CRC_ERR   = 8'h08;
  localparam logic [7:0] R1_PARAM_ERR = 8'h40;

  localparam logic [31:0] DEFAULT_BLOCK_LEN = 32'd512;

  typedef enum logic [2:0] {
    WAIT_START,
    RX_FRAME,
    DECODE,
    NCR,
    TX_R1,
    TX_R7
  } resp_state_e;

  // CMD8 echo: voltage field is accepted only for the 2.7-3.6 V range code.
  function automatic logic [31:0] r7_echo(input logic [31:0] arg);
    return {20'h0, (arg[11:8] == 4'h1) ? 4'h1 : 4'h0, arg[7:0]};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, MSB-first data.
// Shared by the card-side responder and the host command engine.
module sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic feedback;

  assign feedback = bit_in ^ crc[6];

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? 7'h09 : 7'h00);
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// Card side of an SD SPI-mode command link: receives 48-bit frames on D1, answers R1/R7 on D0.
// Define SD_RESP_CRC_CHECK_EN to enable CRC7 checking of command frames (and CMD59).
module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int NCR_BYTES     = 1,
  parameter int INIT_POLLS    = 2,
  parameter int MAX_BLOCK_LEN = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        CS,
  input  logic        D1,
  output logic        D0,
  output logic        D0_oe,
  output logic        card_ready,
  output logic [31:0] block_len,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index
);

  localparam logic [6:0] NCR_LAST = 7'(NCR_BYTES * 8 - 1);

  resp_state_e state;

  logic [FRAME_LEN-1:0] shreg;
  logic [5:0]           bit_cnt;
  logic [6:0]           cnt;
  logic [31:0]          out_sr;
  logic [7:0]           r1_q;
  logic [31:0]          r7_q;
  logic                 send_r7;

  logic                 idle_flag;
  logic                 app_cmd;
  logic [7:0]           poll_cnt;

  // Fields of the completed frame, valid while in DECODE.
  logic [5:0]  f_idx;
  logic [31:0] f_arg;
  logic        frame_ok;
  logic        crc_fail;

  assign f_idx    = shreg[45:40];
  assign f_arg    = shreg[39:8];
  assign frame_ok = !shreg[47] && shreg[46] && shreg[0];

`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] crc_val;
  logic       crc_on;
  logic       d_crc_on;
  logic       crc_en;

  // Clearing throughout WAIT_START is equivalent to having fed the start bit:
  // a 0 shifted into an all-zero CRC leaves it at zero.
  assign crc_en = (state == RX_FRAME) && !CS && (bit_cnt <= 6'd39);

  sd_crc7 u_crc7 (
    .clk    (clk),
    .rst_n  (reset_n),
    .clear  (state != RX_FRAME),
    .en     (crc_en),
    .bit_in (D1),
    .crc    (crc_val)
  );

  assign crc_fail = ((f_idx == CMD0) || (f_idx == CMD8) || crc_on) && (crc_val != shreg[7:1]);
`else
  logic unused_crc_field;

  assign unused_crc_field = ^shreg[7:1];
  assign crc_fail         = 1'b0;
`endif

  // Next card state and response for the frame sitting in shreg.
  logic        d_idle;
  logic        d_ready;
  logic [7:0]  d_poll;
  logic        d_app;
  logic [31:0] d_blen;
  logic [7:0]  d_flags;
  logic [7:0]  d_r1;
  logic        d_r7_en;
  logic [31:0] d_r7;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    d_idle  = idle_flag;
    d_ready = card_ready;
    d_poll  = poll_cnt;
    d_app   = 1'b0;
    d_blen  = block_len;
    d_flags = 8'h00;
    d_r7_en = 1'b0;
    d_r7    = r7_echo(f_arg);
`ifdef SD_RESP_CRC_CHECK_EN
    d_crc_on = crc_on;
`endif

    if (!frame_ok || crc_fail) begin
      d_app   = app_cmd;
      d_flags = R1_CRC_ERR;
    end else begin
      unique case (f_idx)
        CMD0: begin
          d_idle  = 1'b1;
          d_ready = 1'b0;
          d_poll  = 8'd0;
        end
        CMD8:  d_r7_en = 1'b1;
        CMD55: d_app   = 1'b1;
        ACMD41: begin
          if (!app_cmd) begin
            d_flags = R1_ILLEGAL;
          end else if (poll_cnt < 8'(INIT_POLLS)) begin
            d_poll = poll_cnt + 8'd1;
          end else begin
            d_idle  = 1'b0;
            d_ready = 1'b1;
          end
        end
        CMD16: begin
          if (idle_flag) begin
            d_flags = R1_ILLEGAL;
          end else if (f_arg == 32'd0 || f_arg > 32'(MAX_BLOCK_LEN)) begin
            d_flags = R1_PARAM_ERR;
          end else begin
            d_blen = f_arg;
          end
        end
`ifdef SD_RESP_CRC_CHECK_EN
        CMD59: d_crc_on = f_arg[0];
`endif
        default: d_flags = R1_ILLEGAL;
      endcase
    end

    d_r1 = d_flags | {7'b0, d_idle};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_START;
      D0         <= 1'b1;
      D0_oe      <= 1'b0;
      card_ready <= 1'b0;
      block_len  <= DEFAULT_BLOCK_LEN;
      cmd_valid  <= 1'b0;
      cmd_index  <= 6'd0;
      idle_flag  <= 1'b1;
      app_cmd    <= 1'b0;
      poll_cnt   <= 8'd0;
      shreg      <= '0;
      bit_cnt    <= 6'd0;
      cnt        <= 7'd0;
      out_sr     <= '1;
      r1_q       <= 8'hFF;
      r7_q       <= 32'd0;
      send_r7    <= 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
      crc_on     <= 1'b0;
`endif
    end else begin
      D0_oe     <= !CS;
      cmd_valid <= 1'b0;

      if (CS) begin
        state <= WAIT_START;
        D0    <= 1'b1;
      end else begin
        unique case (state)
          WAIT_START: begin
            if (!D1) begin
              shreg   <= {shreg[FRAME_LEN-2:0], D1};
              bit_cnt <= 6'd1;
              state   <= RX_FRAME;
            end
          end

          RX_FRAME: begin
            shreg <= {shreg[FRAME_LEN-2:0], D1};
            if (bit_cnt == 6'(FRAME_LEN - 1)) begin
              // Frame bits 45:40 sit one position lower until this final shift lands.
              cmd_valid <= 1'b1;
              cmd_index <= shreg[44:39];
              state     <= DECODE;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end

          DECODE: begin
            idle_flag  <= d_idle;
            card_ready <= d_ready;
            poll_cnt   <= d_poll;
            app_cmd    <= d_app;
            block_len  <= d_blen;
`ifdef SD_RESP_CRC_CHECK_EN
            crc_on     <= d_crc_on;
`endif
            r1_q    <= d_r1;
            r7_q    <= d_r7;
            send_r7 <= d_r7_en;
            cnt     <= 7'd0;
            D0      <= 1'b1;
            state   <= NCR;
          end

          NCR: begin
            if (cnt == NCR_LAST) begin
              D0     <= r1_q[7];
              out_sr <= {r1_q[6:0], 25'h1FF_FFFF};
              cnt    <= 7'd1;
              state  <= TX_R1;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end

          TX_R1: begin
            if (cnt == 7'd8) begin
              if (send_r7) begin
                D0     <= r7_q[31];
                out_sr <= {r7_q[30:0], 1'b1};
                cnt    <= 7'd1;
                state  <= TX_R7;
              end else begin
                D0    <= 1'b1;
                state <= WAIT_START;
              end
            end else begin
              D0     <= out_sr[31];
              out_sr <= {out_sr[30:0], 1'b1};
              cnt    <= cnt + 7'd1;
            end
          end

          TX_R7: begin
            if (cnt == 7'd32) begin
              D0    <= 1'b1;
              state <= WAIT_START;
            end else begin
              D0     <= out_sr[31];
              out_sr <= {out_sr[30:0], 1'b1};
              cnt    <= cnt + 7'd1;
            end
          end

          default: begin
            D0    <= 1'b1;
            state <= WAIT_START;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: directed bring-up sequence, abort/reset cases,
// then randomized commands scored against a behavioural card model.
module tb_sd_spi_responder;

  localparam int NCR_BYTES     = 1;
  localparam int INIT_POLLS    = 2;
  localparam int MAX_BLOCK_LEN = 512;

  logic        clk;
  logic        reset_n;
  logic        CS;
  logic        D1;
  logic        D0;
  logic        D0_oe;
  logic        card_ready;
  logic [31:0] block_len;
  logic        cmd_valid;
  logic [5:0]  cmd_index;

  sd_spi_responder #(
    .NCR_BYTES     (NCR_BYTES),
    .INIT_POLLS    (INIT_POLLS),
    .MAX_BLOCK_LEN (MAX_BLOCK_LEN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .CS         (CS),
    .D1         (D1),
    .D0         (D0),
    .D0_oe      (D0_oe),
    .card_ready (card_ready),
    .block_len  (block_len),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural card model ----------------
  typedef struct {
    bit          idle;
    bit          app;
    int          polls;
    bit          ready;
    int unsigned blen;
  } card_t;

  card_t card;

  function automatic void model_reset();
    card.idle  = 1'b1;
    card.app   = 1'b0;
    card.polls = 0;
    card.ready = 1'b0;
    card.blen  = 512;
  endfunction

  function automatic void model_cmd(input int idx, input int unsigned arg, input bit stop_ok,
                                    output int r1, output bit has_r7, output int unsigned r7);
    has_r7 = 1'b0;
    r7     = 0;
    if (!stop_ok) begin
      r1 = 8 + int'(card.idle);
      return;
    end
    if (idx != 55) card.app = 1'b0;
    case (idx)
      0: begin
        card.idle  = 1'b1;
        card.ready = 1'b0;
        card.polls = 0;
        r1 = 1;
      end
      8: begin
        has_r7 = 1'b1;
        r7 = (arg & 32'hFF) | ((((arg >> 8) & 32'hF) == 1) ? 32'h100 : 32'h0);
        r1 = int'(card.idle);
      end
      55: begin
        card.app = 1'b1;
        r1 = int'(card.idle);
      end
      41: begin
        // the app flag was already cleared above, so test what it was before this command
        r1 = -1;
      end
      16: begin
        if (card.idle) r1 = 5;
        else if (arg == 0 || arg > MAX_BLOCK_LEN) r1 = 'h40;
        else begin
          card.blen = arg;
          r1 = 0;
        end
      end
      default: r1 = 4 + int'(card.idle);
    endcase
  endfunction

  // ACMD41 depends on whether the previous command was CMD55, so it is resolved here.
  function automatic int model_acmd41(input bit was_app);
    if (!was_app) return 4 + int'(card.idle);
    if (card.polls < INIT_POLLS) begin
      card.polls++;
      return 1;
    end
    card.idle  = 1'b0;
    card.ready = 1'b1;
    return 0;
  endfunction

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg, input logic stop);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, crc7(head), stop};
  endfunction

  // Drive the first nbits of a frame; reports whether cmd_valid fired before the last bit.
  task automatic send_bits(input logic [47:0] frame, input int nbits, output bit early_valid);
    early_valid = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      D1 = frame[47 - i];
      tick();
      if (i < 47 && cmd_valid) early_valid = 1'b1;
    end
    D1 = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg, input logic stop);
    int          exp_r1;
    bit          exp_has_r7;
    int unsigned exp_r7;
    bit          was_app;
    bit          early;
    bit          ncr_bad;
    logic [7:0]  r1;
    logic [31:0] r7;

    was_app = card.app;
    model_cmd(int'(idx), arg, stop, exp_r1, exp_has_r7, exp_r7);
    if (exp_r1 < 0) exp_r1 = model_acmd41(was_app);

    send_bits(make_frame(idx, arg, stop), 48, early);
    check({tag, " early_valid"}, 32'(early), 32'd0);
    check({tag, " cmd_valid"}, 32'(cmd_valid), 32'd1);
    check({tag, " cmd_index"}, 32'(cmd_index), 32'(idx));

    ncr_bad = 1'b0;
    for (int i = 0; i < 8 * NCR_BYTES; i++) begin
      tick();
      if (i == 0) check({tag, " valid_width"}, 32'(cmd_valid), 32'd0);
      if (D0 !== 1'b1) ncr_bad = 1'b1;
    end
    check({tag, " ncr_ones"}, 32'(ncr_bad), 32'd0);

    for (int i = 0; i < 8; i++) begin
      tick();
      r1 = {r1[6:0], D0};
    end
    check({tag, " r1"}, 32'(r1), 32'(exp_r1));

    if (exp_has_r7) begin
      for (int i = 0; i < 32; i++) begin
        tick();
        r7 = {r7[30:0], D0};
      end
      check({tag, " r7"}, r7, exp_r7);
    end

    tick();
    check({tag, " d0_idle"}, 32'(D0), 32'd1);
    check({tag, " d0_oe"}, 32'(D0_oe), 32'd1);
    check({tag, " card_ready"}, 32'(card_ready), 32'(card.ready));
    check({tag, " block_len"}, block_len, card.blen);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " D0"}, 32'(D0), 32'd1);
    check({tag, " D0_oe"}, 32'(D0_oe), 32'd0);
    check({tag, " card_ready"}, 32'(card_ready), 32'd0);
    check({tag, " block_len"}, block_len, 32'd512);
    check({tag, " cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, " cmd_index"}, 32'(cmd_index), 32'd0);
  endtask

  int          sel;
  logic [31:0] rarg;
  bit          early;
  int          unk_idx [5] = '{1, 2, 17, 24, 63};
  int          len_pick;

  initial begin
    reset_n = 1'b0;
    CS      = 1'b1;
    D1      = 1'b1;
    model_reset();
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();
    CS = 1'b0;
    tick();
    check("oe_after_cs", 32'(D0_oe), 32'd1);

    // Bring-up sequence and error responses while idle
    run_cmd("cmd0", 6'd0, 32'h0, 1'b1);
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b1);
    run_cmd("cmd16_idle", 6'd16, 32'd4, 1'b1);
    run_cmd("acmd41_noapp", 6'd41, 32'h4000_0000, 1'b1);
    run_cmd("unknown_3f", 6'h3F, 32'h0, 1'b1);
    run_cmd("bad_stop", 6'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_cmd("cmd55", 6'd55, 32'h0, 1'b1);
      run_cmd("acmd41", 6'd41, 32'h4000_0000, 1'b1);
    end
    check("ready_after_acmd41", 32'(card_ready), 32'd1);
    run_cmd("cmd16_4", 6'd16, 32'd4, 1'b1);
    run_cmd("cmd16_1024", 6'd16, 32'd1024, 1'b1);
    run_cmd("cmd16_512", 6'd16, 32'd512, 1'b1);

    // Partial CMD0 aborted by CS: no strobe, no change to the ready card
    send_bits(make_frame(6'd0, 32'h0, 1'b1), 20, early);
    CS = 1'b1;
    tick();
    tick();
    check("abort early_valid", 32'(early), 32'd0);
    check("abort cmd_valid", 32'(cmd_valid), 32'd0);
    check("abort D0", 32'(D0), 32'd1);
    check("abort D0_oe", 32'(D0_oe), 32'd0);
    check("abort card_ready", 32'(card_ready), 32'd1);
    CS = 1'b0;
    tick();
    run_cmd("cmd0_after_abort", 6'd0, 32'h0, 1'b1);

    // Reset pulsed in the middle of an R7 payload
    send_bits(make_frame(6'd8, 32'h0000_01AA, 1'b1), 48, early);
    repeat (8 * NCR_BYTES + 8 + 10) tick();
    reset_n = 1'b0;
    #2;
    check_reset_values("mid_r7_reset");
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();
    run_cmd("cmd0_after_reset", 6'd0, 32'h0, 1'b1);

    // Randomized command stream
    for (int n = 0; n < 80; n++) begin
      sel  = $urandom_range(0, 9);
      rarg = $urandom;
      case (sel)
        0: run_cmd("rnd_cmd0", 6'd0, rarg, 1'b1);
        1: begin
          if ($urandom_range(0, 1) == 1) rarg[11:8] = 4'h1;
          run_cmd("rnd_cmd8", 6'd8, rarg, 1'b1);
        end
        2, 3: begin
          run_cmd("rnd_cmd55", 6'd55, rarg, 1'b1);
          run_cmd("rnd_acmd41", 6'd41, 32'h4000_0000, 1'b1);
        end
        4: run_cmd("rnd_41_bare", 6'd41, rarg, 1'b1);
        5, 6: begin
          len_pick = $urandom_range(0, 5);
          case (len_pick)
            0: rarg = 32'd0;
            1: rarg = 32'd1;
            2: rarg = 32'($urandom_range(1, MAX_BLOCK_LEN));
            3: rarg = 32'd512;
            4: rarg = 32'd513;
            default: rarg = $urandom;
          endcase
          run_cmd("rnd_cmd16", 6'd16, rarg, 1'b1);
        end
        7: run_cmd("rnd_unknown", 6'(unk_idx[$urandom_range(0, 4)]), rarg, 1'b1);
        8: run_cmd("rnd_bad_stop", 6'($urandom_range(0, 63)), rarg, 1'b0);
        default: run_cmd("rnd_cmd55_only", 6'd55, rarg, 1'b1);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- Synthesizable SD-card SPI-mode responder: the card-side end of the command/response link driven by the host init sequencer and command engine.
- Deserializes 48-bit command frames from D1 (MOSI), tracks minimal card state (idle, app-cmd, ready, block length), and serializes R1/R7 responses on D0 (MISO).
- Used as a simulation and FPGA-loopback stand-in for a real card, one bit per clk.

Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes between the frame stop bit and the R1 MSB (allowed 1-8).
- INIT_POLLS, 2, number of ACMD41s after CMD0 that return 0x01 before the card reports ready (0x00).
- MAX_BLOCK_LEN, 512, largest legal CMD16 argument.

Ports:
- clk  in  1  system clock; one SPI bit per cycle.
- reset_n  in  1  asynchronous active-low reset.
- CS  in  1  chip select, active low.
- D1  in  1  MOSI: host command bits, MSB first, sampled on posedge clk while CS=0.
- D0  out  1  MISO: response bits; 1 when idle.
- D0_oe  out  1  1 while CS=0; host-side tristate control.
- card_ready  out  1  1 once ACMD41 has returned 0x00.
- block_len  out  32  current block length set by CMD16.
- cmd_valid  out  1  one-cycle strobe when a complete frame is decoded.
- cmd_index  out  6  index of the last decoded command.

Behaviour:
- Reset values:
  - D0=1, D0_oe=0, card_ready=0, block_len=512, cmd_valid=0, cmd_index=0.
  - Internal: idle_flag=1, app_cmd=0, poll_cnt=0, FSM=WAIT_START.
- FSM states: WAIT_START, RX_FRAME, DECODE, NCR, TX_R1, TX_R7.
- WAIT_START: while CS=0, a 0 sampled on D1 is the start bit. Go to RX_FRAME with the bit counter at 1.
- RX_FRAME: shift D1 into a 48-bit register. After bit 47 is sampled, go to DECODE.
- Frame check: bit 46 must be 1 (transmission bit) and bit 0 must be 1 (stop bit). Otherwise R1 = 0x08 | idle_flag.
- DECODE (1 cycle): pulse cmd_valid, latch cmd_index, compute R1, update card state, go to NCR.
- Command handling (R1 bit 0 = idle_flag after the update):
  - CMD0: idle_flag=1, card_ready=0, poll_cnt=0, app_cmd=0. R1=0x01.
  - CMD8: R1 = idle_flag. Then R7 payload = {20'h0, arg[11:8] when arg[11:8]==4'h1 else 4'h0, arg[7:0]}. Arg 0x000001AA echoes 0x000001AA.
  - CMD55: app_cmd=1. R1 = idle_flag.
  - ACMD41 (index 41 with app_cmd=1):
    - If poll_cnt < INIT_POLLS: poll_cnt++, R1=0x01.
    - Else: idle_flag=0, card_ready=1, R1=0x00.
    - poll_cnt saturates.
  - Index 41 with app_cmd=0: illegal.
  - CMD16:
    - If idle_flag=1: illegal.
    - Else if arg==0 or arg>MAX_BLOCK_LEN: R1=0x40 and block_len unchanged.
    - Else: block_len=arg, R1=0x00.
  - Any other index: illegal. Illegal means R1 = 0x04 | idle_flag.
  - app_cmd clears on every decoded command except CMD55.
- NCR: D0=1 for NCR_BYTES*8 cycles.
- TX_R1: 8 bits MSB first. Then go to TX_R7 (32 bits MSB first) if the command was CMD8 with R1 bit 2 clear; else go to WAIT_START.
- Latency: with the stop bit sampled in cycle N, the R1 MSB appears on D0 in cycle N+2+8*NCR_BYTES (one DECODE cycle).
- D1 is ignored from DECODE through the end of TX. A new start bit is accepted only in WAIT_START.
- CS rising at any state:
  - Abort to WAIT_START, D0=1, D0_oe=0.
  - A partial frame is discarded and causes no state change.
  - Card state changes already made in DECODE persist.
- reset_n low mid-frame or mid-response: immediate return to reset values.

Optional Feature:
- Macro: SD_RESP_CRC_CHECK_EN.
- Defined: CRC7 (poly x^7+x^3+1) is computed over frame bits 47:8 and compared with bits 7:1.
  - CMD0 and CMD8 are always checked.
  - Other commands are checked only after CMD59 with arg[0]=1 enables checking; CMD59 itself returns R1 = idle_flag.
  - On mismatch: R1 = 0x08 | idle_flag, no state change, no R7.
- Undefined: the CRC field is ignored, and CMD59 is illegal.

Decomposition:
- Shared package sd_pkg:
  - Command index constants (CMD0, CMD8, CMD16, CMD55, ACMD41, CMD59).
  - R1 bit constants (IDLE=0x01, ILLEGAL=0x04, CRC_ERR=0x08, PARAM_ERR=0x40).
  - Responder state enum.
  - Frame length 48.
- Sub-module sd_crc7: serial CRC7 with bit-enable and clear. The host command engine reuses it.

Test Plan:
- Reset, then CMD0 frame 40 00000000 95 -> cmd_valid pulse, cmd_index=0; after 8 bits of 1s, D0 shifts 0x01.
- CMD8 arg 0x000001AA crc 0x87 -> R1 0x01 then 32 bits 0x000001AA.
- CMD55/ACMD41 (arg 0x40000000) x3 with INIT_POLLS=2 -> R1 sequence 0x01, 0x01, 0x00; card_ready=1 after the third.
- CMD16 arg 4 after ready -> R1 0x00, block_len=4. Then CMD16 arg 1024 -> R1 0x40, block_len stays 4. CMD16 before ready -> R1 0x05.
- ACMD41 without CMD55, and unknown index 0x3F -> R1 0x05 when idle. Frame with stop bit 0 -> R1 0x09.
- CS deasserted after 20 frame bits, then a full CMD0 -> no cmd_valid for the partial frame; CMD0 gets a normal 0x01. Repeat with reset_n pulsed mid-R7 -> outputs at reset values.
